// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signal bundle for load_store_unit.
//   slave  : the load/store unit itself (takes requests, drives the memory)
//   master : the execute stage plus memory model on the other side
// Signals:
//   req_valid/req_ready handshake, req_write, req_size, req_signed,
//   req_addr, req_wdata          : execute-stage request
//   resp_valid, resp_rdata, resp_err : single-cycle response
//   mem_enable, mem_rd, mem_wr, mem_address, mem_data_in, mem_data_out
//                                : 256-word data memory port
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_enable;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
               mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_enable, mem_rd, mem_wr, mem_address, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
               mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_enable, mem_rd, mem_wr, mem_address, mem_data_in
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed load/store requests into word-wide
// memory cycles, with read-modify-write for byte/halfword stores and
// lane extraction plus sign/zero extension for sub-word loads.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : load_store_unit_if.slave (request, response and memory signals)
// Optional build macro LSU_ALIGN_CHECK_EN: misaligned halfword/word requests
// complete immediately with resp_err=1 and no memory cycle. Without it the
// low address bits are forced to alignment and resp_err stays 0.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// READ      | memory read cycle for a load
// EXTRACT   | capture lane of read data into resp_rdata
// RMW_RD    | memory read cycle for a sub-word store
// RMW_MERGE | splice store data into the read word
// WRITE     | memory write cycle
// DONE      | resp_valid pulse
module load_store_unit #(
    parameter int MEM_AW = 8,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam int AW = MEM_AW + 2;

    typedef enum logic [2:0] {
        IDLE, READ, EXTRACT, RMW_RD, RMW_MERGE, WRITE, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0] merged_q, merged_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [AW-1:0]     acc_addr;
    logic              misaligned;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] store_merge;
    logic              ready, en, rd, wr;
    logic              unused_addr_bits;

    // Upper address bits fall outside the 256-word memory and wrap away.
    assign unused_addr_bits = ^bus.req_addr[DATA_W-1:AW];

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (bus.req_size == 2'b01 && bus.req_addr[0])
            misaligned = 1'b1;
        else if (bus.req_size[1] && bus.req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end
    assign acc_addr = bus.req_addr[AW-1:0];
`else
    assign misaligned = 1'b0;
    always_comb begin
        acc_addr = bus.req_addr[AW-1:0];
        if (bus.req_size[1])
            acc_addr[1:0] = 2'b00;
        else if (bus.req_size[0])
            acc_addr[0] = 1'b0;
    end
`endif

    // Little-endian lane select; size 11 behaves as a word.
    always_comb begin
        lane_byte   = bus.mem_data_out[{addr_q[1:0], 3'b000} +: 8];
        lane_half   = bus.mem_data_out[{addr_q[1], 4'b0000} +: 16];
        load_ext    = bus.mem_data_out;
        store_merge = bus.mem_data_out;
        case (size_q)
            2'b00: begin
                load_ext = signed_q ? {{(DATA_W-8){lane_byte[7]}}, lane_byte}
                                    : {{(DATA_W-8){1'b0}}, lane_byte};
                store_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = signed_q ? {{(DATA_W-16){lane_half[15]}}, lane_half}
                                    : {{(DATA_W-16){1'b0}}, lane_half};
                store_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        ready    = 1'b0;
        en       = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d   = acc_addr;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    write_d  = bus.req_write;
                    wdata_d  = bus.req_wdata[15:0];
                    err_d    = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else if (!bus.req_write) begin
                        state_d = READ;
                    end else if (bus.req_size[1]) begin
                        // Word stores skip the merge; the write data goes straight out.
                        merged_d = bus.req_wdata;
                        state_d  = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            READ: begin
                en      = 1'b1;
                rd      = 1'b1;
                state_d = EXTRACT;
            end
            EXTRACT: begin
                rdata_d = load_ext;
                state_d = DONE;
            end
            RMW_RD: begin
                en      = 1'b1;
                rd      = 1'b1;
                state_d = RMW_MERGE;
            end
            RMW_MERGE: begin
                merged_d = store_merge;
                state_d  = WRITE;
            end
            WRITE: begin
                en      = 1'b1;
                wr      = 1'b1;
                rdata_d = '0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.resp_valid  = (state_q == DONE);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.mem_enable  = en;
    assign bus.mem_rd      = rd;
    assign bus.mem_wr      = wr;
    assign bus.mem_address = {{(DATA_W-MEM_AW){1'b0}}, addr_q[AW-1:2]};
    assign bus.mem_data_in = merged_q;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_fill = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fill_val(int i);
        return (32'(i) * 32'h0100_0193) ^ 32'h5A3C_96E1;
    endfunction

    // Memory model: write on mem_wr, read data registered one cycle after mem_rd.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill_val(i);
        end else if (bus.mem_enable && bus.mem_wr) begin
            mem[bus.mem_address[7:0]] <= bus.mem_data_in;
        end
        if (bus.mem_enable && bus.mem_rd) bus.mem_data_out <= mem[bus.mem_address[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what a request must produce, from the word array alone.
    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
        logic [7:0]  widx;
        logic [31:0] wword;
    } exp_t;

    logic [31:0] ref_mem [256];

    function automatic exp_t model(logic w, logic [1:0] sz, logic sg, logic [31:0] a,
                                   logic [31:0] wd);
        exp_t e;
        int bytes, sh;
        logic [31:0] old, mask, v;
        bytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        sh = (bytes == 1) ? 8 * a[1:0] : (bytes == 2) ? 16 * a[1] : 0;
        e.widx = a[9:2];
        old = ref_mem[a[9:2]];
        e.err = 1'b0; e.nrd = 0; e.nwr = 0; e.wword = 0; e.rdata = 0; e.lat = 0;
`ifdef LSU_ALIGN_CHECK_EN
        if (bytes > 1 && (a % bytes) != 0) begin
            e.lat = 1;
            e.err = 1'b1;
            return e;
        end
`endif
        if (!w) begin
            e.lat = 3; e.nrd = 1;
            v = old >> sh;
            if (bytes == 1) begin
                v = v & 32'hFF;
                if (sg && v[7]) v = v | 32'hFFFF_FF00;
            end else if (bytes == 2) begin
                v = v & 32'hFFFF;
                if (sg && v[15]) v = v | 32'hFFFF_0000;
            end
            e.rdata = v;
        end else if (bytes == 4) begin
            e.lat = 2; e.nwr = 1; e.wword = wd;
        end else begin
            e.lat = 4; e.nrd = 1; e.nwr = 1;
            mask = ((bytes == 1) ? 32'hFF : 32'hFFFF) << sh;
            e.wword = (old & ~mask) | ((wd << sh) & mask);
        end
        return e;
    endfunction

    exp_t        cur;
    bit          busy = 1'b0;
    int          acc_cyc = 0;
    int          nrd = 0, nwr = 0;
    logic [31:0] last_rdata = 0, last_wr_addr = 0, last_wr_data = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_fill) for (int i = 0; i < 256; i++) ref_mem[i] = fill_val(i);
            busy = 1'b0;
            last_rdata = 0;
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_resp_rdata", bus.resp_rdata, 0);
            chk("rst_resp_err", bus.resp_err, 0);
            chk("rst_mem_ctl", {bus.mem_enable, bus.mem_rd, bus.mem_wr}, 0);
            chk("rst_mem_address", bus.mem_address, 0);
            chk("rst_mem_data_in", bus.mem_data_in, 0);
        end else begin
            chk("ready_vs_busy", bus.req_ready, !busy);
            chk("rd_wr_excl", bus.mem_rd & bus.mem_wr, 0);
            chk("enable_decode", bus.mem_enable, bus.mem_rd | bus.mem_wr);
            if (bus.mem_rd) begin
                chk("rd_in_flight", busy, 1);
                chk("rd_addr", bus.mem_address, {24'h0, cur.widx});
                nrd++;
            end
            if (bus.mem_wr) begin
                chk("wr_in_flight", busy, 1);
                chk("wr_addr", bus.mem_address, {24'h0, cur.widx});
                chk("wr_data", bus.mem_data_in, cur.wword);
                ref_mem[cur.widx] = cur.wword;
                last_wr_addr = bus.mem_address;
                last_wr_data = bus.mem_data_in;
                nwr++;
            end
            if (bus.resp_valid) begin
                chk("resp_in_flight", busy, 1);
                chk("latency", cyc - acc_cyc, cur.lat);
                chk("resp_rdata", bus.resp_rdata, cur.rdata);
                chk("resp_err", bus.resp_err, cur.err);
                chk("mem_reads", nrd, cur.nrd);
                chk("mem_writes", nwr, cur.nwr);
                last_rdata = cur.rdata;
                busy = 1'b0;
            end else begin
                chk("rdata_hold", bus.resp_rdata, last_rdata);
            end
            if (bus.req_valid && bus.req_ready) begin
                cur = model(bus.req_write, bus.req_size, bus.req_signed, bus.req_addr,
                            bus.req_wdata);
                busy = 1'b1;
                acc_cyc = cyc;
                nrd = 0;
                nwr = 0;
            end
        end
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er);
        bit got;
        got = 1'b0; rd = 0; er = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                rd = bus.resp_rdata;
                er = bus.resp_err;
            end
        end
        chk("resp_timeout", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        send(w, sz, sg, a, wd);
        wait_resp(rd, er);
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        er;
        int          t_a, r, k;
        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        mem_fill = 1'b0;
        rst = 1'b0;

        xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er);
        chk("t1_store_rdata", rd, 0);
        chk("t1_wr_addr", last_wr_addr, 32'd4);
        xact(0, 2'b10, 0, 32'h10, 0, rd, er);
        chk("t1_load_word", rd, 32'hDEADBEEF);

        xact(1, 2'b00, 0, 32'h11, 32'h000000A5, rd, er);
        chk("t2_merged_write", last_wr_data, 32'hDEADA5EF);
        xact(0, 2'b10, 0, 32'h10, 0, rd, er);
        chk("t2_load_word", rd, 32'hDEADA5EF);

        xact(0, 2'b00, 1, 32'h11, 0, rd, er);
        chk("t3_lb_signed", rd, 32'hFFFFFFA5);
        xact(0, 2'b00, 0, 32'h11, 0, rd, er);
        chk("t3_lb_unsigned", rd, 32'h000000A5);
        xact(0, 2'b01, 1, 32'h12, 0, rd, er);
        chk("t3_lh_signed", rd, 32'hFFFFDEAD);
        xact(0, 2'b01, 0, 32'h10, 0, rd, er);
        chk("t3_lh_unsigned", rd, 32'h0000A5EF);

        // Two loads with req_valid held high across them.
        send(0, 2'b10, 0, 32'h10, 0);
        t_a = cyc;
        send(0, 2'b00, 1, 32'h13, 0);
        chk("t4_b2b_gap", cyc - t_a, 4);
        wait_resp(rd, er);
        chk("t4_second_load", rd, 32'hFFFFFFDE);

        // Reset during RMW_MERGE of a byte store.
        send(1, 2'b00, 0, 32'h10, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_mem_ctl_drop", {bus.mem_enable, bus.mem_rd, bus.mem_wr}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        xact(0, 2'b10, 0, 32'h10, 0, rd, er);
        chk("t5_word_kept", rd, 32'hDEADA5EF);

        xact(0, 2'b10, 0, 32'h13, 0, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
        chk("t6_err", er, 1);
        chk("t6_rdata", rd, 0);
`else
        chk("t6_err", er, 0);
        chk("t6_rdata", rd, 32'hDEADA5EF);
`endif

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            a = $urandom;
            a[9:2] = 8'd252 + 8'($urandom_range(0, 7));
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, $urandom);
            if (r < 5) begin
                k = $urandom_range(0, 4);
                repeat (k) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end else if (r < 60) begin
                wait_resp(rd, er);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage sitting directly upstream of the 256-word data memory. Accepts byte-addressed load/store requests from the execute stage through a valid/ready handshake. Converts each request into word-granular memory enable/read/write cycles, performing read-modify-write for sub-word stores. Extracts and sign/zero-extends sub-word load data and returns a single-cycle response.

Parameters:
MEM_AW, 8, word-address width driven to the memory (256 words)
DATA_W, 32, data width; fixed at 32 and not intended to be changed

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted on the edge where req_valid & req_ready
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data; sub-word data in the low bits
resp_valid  output  1  one-cycle pulse at request completion
resp_rdata  output  32  load result; 0 for stores; held until the next response
resp_err  output  1  error flag, qualified by resp_valid
mem_enable  output  1  to memory MemEnable
mem_rd  output  1  to memory MemRd
mem_wr  output  1  to memory MemWr
mem_address  output  32  word address {zeros, addr[MEM_AW+1:2]}
mem_data_in  output  32  write data to memory
mem_data_out  input  32  memory read data; valid the cycle after mem_rd is sampled

Behaviour:
- Reset is asynchronous, active-high, and is the only reset source:
  - FSM goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_enable, mem_rd and mem_wr deassert immediately. They are decoded from state only.
  - mem_address and mem_data_in go to 0.
- Acceptance:
  - On the accept edge, addr, size, signed flag, write flag and wdata are latched.
  - req_* inputs are ignored while busy.
- Endianness is little-endian.
  - Byte lane k = bits[8k+7:8k], selected by addr[1:0].
  - Halfword selected by addr[1]: 0 = bits[15:0], 1 = bits[31:16].
- FSM states: IDLE, READ, EXTRACT, RMW_RD, RMW_MERGE, WRITE, DONE.
- Transitions out of IDLE on accept:
  - load -> READ
  - word store -> WRITE
  - sub-word store -> RMW_RD
- READ and RMW_RD: mem_enable=1, mem_rd=1. Next state is EXTRACT or RMW_MERGE respectively.
- EXTRACT:
  - Sample mem_data_out, select the lane, extend per the latched signed flag.
  - Register the result into resp_rdata.
  - Next state DONE.
- RMW_MERGE:
  - Replace the addressed byte/halfword of mem_data_out with the low bits of wdata.
  - Hold the merged word in an internal register.
  - Next state WRITE.
- WRITE:
  - mem_enable=1, mem_wr=1, mem_data_in = merged word (sub-word) or wdata (word).
  - Next state DONE.
- DONE:
  - resp_valid=1 for exactly one cycle. resp_rdata is cleared to 0 for stores.
  - Next state IDLE.
- resp_valid and req_ready are never high in the same cycle.
- Latency, with accept at edge T:
  - word store: resp_valid during cycle T+2
  - load: resp_valid during cycle T+3
  - sub-word store: resp_valid during cycle T+4
- Throughput: the next request can be accepted on the edge that leaves DONE + 1, i.e. once back in IDLE.
- mem_rd and mem_wr are never asserted together. mem_enable is high exactly when either one is high.
- Reset mid-operation: abort with no further memory cycles. A reset before WRITE leaves the target word unchanged.
- Address bits above MEM_AW+1 are ignored. The memory wraps modulo 256 words.

Optional Feature:
Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Misaligned means a halfword with addr[0]=1, or a word (size 10/11) with addr[1:0]!=0.
  - A misaligned request is accepted and goes IDLE -> DONE directly.
  - No memory cycle is issued.
  - resp_err=1 and resp_rdata=0. resp_valid appears during cycle T+1.
- Not defined:
  - Low address bits are forced to alignment: a halfword ignores addr[0], a word ignores addr[1:0].
  - resp_err is tied to 0.

Test Plan:
1. Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_address=4, mem_wr pulse 1 cycle, store resp_valid at T+2; load resp_rdata=0xDEADBEEF at T+3.
2. Continuing from 1, byte store 0xA5 @0x11 -> one mem_rd cycle, then one mem_wr with mem_data_in=0xDEADA5EF; subsequent word load returns 0xDEADA5EF.
3. Continuing from 2:
   - signed byte load @0x11 -> 0xFFFFFFA5
   - unsigned byte load -> 0x000000A5
   - signed half load @0x12 -> 0xFFFFDEAD
   - unsigned half load @0x10 -> 0x0000A5EF
4. req_valid held high with two back-to-back loads -> req_ready=0 from accept through DONE; second accepted only in IDLE; exactly one resp_valid pulse per request.
5. rst asserted asynchronously during RMW_MERGE of byte store 0x00 @0x10 -> mem_* drop immediately, no mem_wr ever; later word load @0x10 returns the prior value.
6. Word load @0x13:
   - with LSU_ALIGN_CHECK_EN -> resp_err=1, resp_rdata=0, no mem_enable, resp_valid at T+1
   - without the macro -> reads word 4, resp_err=0
